// File: rtl/bpu_res_queue_pkg.sv
// Shared sizing constants for the branch resolution queue.
// DEPTH must stay a power of two so tag arithmetic wraps naturally.
package bpu_res_queue_pkg;

    localparam int unsigned BPU_RQ_DEPTH = 8;
    localparam int unsigned BPU_RQ_HLEN  = 4;

endpackage

// File: rtl/bpu_res_queue.sv
// In-flight branch tracker: fetch allocates by tag, the branch unit resolves out of order,
// and resolved entries retire in order as registered predictor updates.
module bpu_res_queue
    import bpu_res_queue_pkg::*;
#(
    parameter int unsigned DEPTH = BPU_RQ_DEPTH,
    parameter int unsigned HLEN  = BPU_RQ_HLEN,
    localparam int unsigned TAGW = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            pred_valid_i,
    output logic            pred_ready_o,
    input  logic [HLEN-1:0] pred_hist_i,
    input  logic            pred_taken_i,
    output logic [TAGW-1:0] pred_tag_o,
    input  logic            res_valid_i,
    input  logic [TAGW-1:0] res_tag_i,
    input  logic            res_taken_i,
    output logic            mispred_o,
    output logic [TAGW-1:0] mispred_tag_o,
    output logic            upd_valid_o,
    output logic            upd_taken_o,
    output logic [HLEN-1:0] upd_hist_o
);

    typedef struct packed {
        logic            resolved;
        logic [HLEN-1:0] hist;
        logic            pred_taken;
        logic            act_taken;
    } entry_t;

    localparam logic [TAGW:0] FULL_CNT = (TAGW+1)'(DEPTH);

    logic [TAGW-1:0]  head_q, head_d;
    logic [TAGW-1:0]  tail_q, tail_d;
    logic [TAGW:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];

    logic            upd_valid_q, upd_taken_q;
    logic [HLEN-1:0] upd_hist_q;
    logic            mispred_q;
    logic [TAGW-1:0] mispred_tag_q;

    logic            res_hit, mispredict, retire, alloc;
    logic [TAGW-1:0] res_age;

    assign res_hit    = res_valid_i && valid_q[res_tag_i] && !ent_q[res_tag_i].resolved;
    assign mispredict = res_hit && (res_taken_i != ent_q[res_tag_i].pred_taken);
    assign retire     = valid_q[head_q] && ent_q[head_q].resolved;
    // Ages are measured from head so wrap-around needs no special casing.
    assign res_age    = res_tag_i - head_q;

    assign pred_ready_o = (count_q != FULL_CNT) && !mispredict && !flush_i;
    assign alloc        = pred_valid_i && pred_ready_o;
    assign pred_tag_o   = tail_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end

        if (res_hit) begin
            ent_d[res_tag_i].resolved  = 1'b1;
            ent_d[res_tag_i].act_taken = res_taken_i;
        end

        if (mispredict) begin
            // Squash everything younger than the mispredicted branch.
            for (int i = 0; i < DEPTH; i++) begin
                if (TAGW'(i) - head_q > res_age) begin
                    valid_d[i] = 1'b0;
                end
            end
            tail_d  = res_tag_i + TAGW'(1);
            count_d = (TAGW+1)'(res_age) + (TAGW+1)'(1) - (TAGW+1)'(retire);
        end else begin
            count_d = count_q + (TAGW+1)'(alloc) - (TAGW+1)'(retire);
        end

        if (retire) begin
            valid_d[head_q]        = 1'b0;
            ent_d[head_q].resolved = 1'b0;
            head_d                 = head_q + TAGW'(1);
        end

        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            ent_d[tail_q]   = '{resolved: 1'b0, hist: pred_hist_i,
                                pred_taken: pred_taken_i, act_taken: 1'b0};
            tail_d          = tail_q + TAGW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            upd_valid_q   <= 1'b0;
            upd_taken_q   <= 1'b0;
            upd_hist_q    <= '0;
            mispred_q     <= 1'b0;
            mispred_tag_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            upd_valid_q <= retire;
            if (retire) begin
                upd_taken_q <= ent_q[head_q].act_taken;
                upd_hist_q  <= ent_q[head_q].hist;
            end
            mispred_q <= mispredict;
            if (mispredict) begin
                mispred_tag_q <= res_tag_i;
            end
        end
    end

    assign upd_valid_o   = upd_valid_q;
    assign upd_taken_o   = upd_taken_q;
    assign upd_hist_o    = upd_hist_q;
    assign mispred_o     = mispred_q;
    assign mispred_tag_o = mispred_tag_q;

    // A resolution must target a live, still-unresolved entry.
    assert property (@(posedge clk_i) disable iff (rst_i || flush_i) res_valid_i |-> res_hit)
        else $error("resolution of stale or already-resolved tag %0d", res_tag_i);

endmodule

// File: tb/tb_bpu_res_queue.sv
// Randomised scoreboard bench for bpu_res_queue against an age-ordered queue model.
module tb_bpu_res_queue;
    import bpu_res_queue_pkg::*;

    localparam int DEPTH = BPU_RQ_DEPTH;
    localparam int HLEN  = BPU_RQ_HLEN;
    localparam int TAGW  = $clog2(DEPTH);

    logic            clk_i = 1'b0;
    logic            rst_i, flush_i;
    logic            pred_valid_i, pred_ready_o, pred_taken_i;
    logic [HLEN-1:0] pred_hist_i;
    logic [TAGW-1:0] pred_tag_o;
    logic            res_valid_i, res_taken_i;
    logic [TAGW-1:0] res_tag_i;
    logic            mispred_o;
    logic [TAGW-1:0] mispred_tag_o;
    logic            upd_valid_o, upd_taken_o;
    logic [HLEN-1:0] upd_hist_o;

    bpu_res_queue #(.DEPTH(DEPTH), .HLEN(HLEN)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .pred_valid_i (pred_valid_i),
        .pred_ready_o (pred_ready_o),
        .pred_hist_i  (pred_hist_i),
        .pred_taken_i (pred_taken_i),
        .pred_tag_o   (pred_tag_o),
        .res_valid_i  (res_valid_i),
        .res_tag_i    (res_tag_i),
        .res_taken_i  (res_taken_i),
        .mispred_o    (mispred_o),
        .mispred_tag_o(mispred_tag_o),
        .upd_valid_o  (upd_valid_o),
        .upd_taken_o  (upd_taken_o),
        .upd_hist_o   (upd_hist_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: live branches oldest-first, each remembering its tag.
    typedef struct {
        int              tag;
        logic [HLEN-1:0] hist;
        bit              pred;
        bit              resolved;
        bit              act;
    } ment_t;
    typedef struct {
        int              due;
        bit              taken;
        logic [HLEN-1:0] hist;
    } upd_t;
    typedef struct {
        int due;
        int tag;
    } mis_t;

    ment_t mq[$];
    int    m_head = 0;
    upd_t  exp_upd[$];
    mis_t  exp_mis[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int mtail();
        return (m_head + mq.size()) % DEPTH;
    endfunction

    // One clock of stimulus; expectations come from the model only.
    task automatic step(input bit pv, input logic [HLEN-1:0] ph, input bit pt, input bit rv,
                        input int rtag, input bit rt, input bit fl, input bit rs);
        int now, idx, tail_e;
        bit ret, mis, ready_e, hit;
        @(negedge clk_i);
        now          = cyc;
        rst_i        = rs;
        flush_i      = fl;
        pred_valid_i = pv;
        pred_hist_i  = ph;
        pred_taken_i = pt;
        res_valid_i  = rv;
        res_tag_i    = TAGW'(rtag);
        res_taken_i  = rt;
        idx = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == rtag) idx = i;
        end
        hit     = rv && idx >= 0 && !mq[idx].resolved;
        mis     = hit && (rt != mq[idx].pred);
        ret     = mq.size() > 0 && mq[0].resolved;
        ready_e = mq.size() < DEPTH && !mis && !fl;
        tail_e  = mtail();
        #1;
        if (!rs) begin
            check("pred_ready", pred_ready_o, ready_e);
            check("pred_tag", pred_tag_o, tail_e);
        end
        @(posedge clk_i);
        if (rs || fl) begin
            mq.delete();
            m_head = 0;
        end else begin
            if (hit) begin
                mq[idx].resolved = 1;
                mq[idx].act      = rt;
            end
            if (mis) begin
                while (mq.size() > idx + 1) void'(mq.pop_back());
                exp_mis.push_back('{now + 1, rtag});
            end
            if (ret) begin
                exp_upd.push_back('{now + 1, mq[0].act, mq[0].hist});
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (pv && ready_e) mq.push_back('{tail_e, ph, pt, 0, 0});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input logic [HLEN-1:0] h, input bit p);
        step(1, h, p, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input int tag, input bit t);
        step(0, '0, 0, 1, tag, t, 0, 0);
    endtask

    function automatic bit pred_of(input int tag);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == tag) return mq[i].pred;
        end
        return 0;
    endfunction

    // Monitor: updates and mispredict pulses must appear exactly when scheduled.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (exp_upd.size() > 0 && exp_upd[0].due == cyc) begin
                check("upd_valid", upd_valid_o, 1);
                check("upd_taken", upd_taken_o, exp_upd[0].taken);
                check("upd_hist", upd_hist_o, exp_upd[0].hist);
                void'(exp_upd.pop_front());
            end else begin
                check("upd_valid_idle", upd_valid_o, 0);
            end
            if (exp_mis.size() > 0 && exp_mis[0].due == cyc) begin
                check("mispred", mispred_o, 1);
                check("mispred_tag", mispred_tag_o, exp_mis[0].tag);
                void'(exp_mis.pop_front());
            end else begin
                check("mispred_idle", mispred_o, 0);
            end
        end
    end

    initial begin
        int ures[$];
        int pick, a_pct, r_pct;
        bit p;

        step(0, '0, 0, 0, 0, 0, 0, 1);
        step(0, '0, 0, 0, 0, 0, 0, 1);
        mon_en = 1;
        idle(1);

        // In-order resolution
        alloc(4'd3, 1);
        alloc(4'd5, 0);
        resolve(0, 1);
        resolve(1, 0);
        idle(4);

        // Out-of-order resolution
        step(0, '0, 0, 0, 0, 0, 1, 0);
        alloc(4'd1, 0);
        alloc(4'd2, 1);
        alloc(4'd7, 0);
        resolve(2, 0);
        resolve(1, 1);
        idle(2);
        resolve(0, 0);
        idle(5);

        // Mispredict squash
        step(0, '0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) alloc(4'(i + 8), 1);
        resolve(1, 0);
        alloc(4'd12, 0);
        resolve(0, 1);
        resolve(2, 0);
        idle(5);

        // Full queue, refused allocation, pointer wrap
        step(0, '0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) alloc(4'(i), i[0]);
        alloc(4'd15, 1);
        step(1, 4'd14, 0, 1, 0, 0, 0, 0);
        step(1, 4'd14, 0, 1, 1, 1, 0, 0);
        step(1, 4'd14, 0, 1, 2, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 3; i++) alloc(4'(i + 9), 0);
        for (int t = 3; t < DEPTH + 3; t++) resolve(t % DEPTH, pred_of(t % DEPTH));
        idle(12);

        // Flush with concurrent resolve and allocate
        step(0, '0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) alloc(4'(i + 4), 0);
        resolve(1, 0);
        resolve(2, 0);
        step(1, 4'd9, 1, 1, 3, 1, 1, 0);
        idle(3);

        // Randomised traffic in alternating fill/drain phases
        for (int n = 0; n < 4000; n++) begin
            a_pct = ((n / 200) % 2 == 0) ? 85 : 30;
            r_pct = ((n / 200) % 2 == 0) ? 35 : 85;
            ures.delete();
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].resolved) ures.push_back(mq[i].tag);
            end
            if (ures.size() > 0 && $urandom_range(0, 99) < r_pct) begin
                pick = ures[$urandom_range(0, ures.size() - 1)];
                p    = pred_of(pick);
                step($urandom_range(0, 99) < a_pct, HLEN'($urandom), $urandom_range(0, 1) == 1,
                     1, pick, ($urandom_range(0, 3) == 0) ? !p : p,
                     $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
            end else begin
                step($urandom_range(0, 99) < a_pct, HLEN'($urandom), $urandom_range(0, 1) == 1,
                     0, 0, 0, $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
            end
        end

        // Drain everything that is still live
        for (int n = 0; n < 100 && mq.size() > 0; n++) begin
            pick = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].resolved && pick < 0) pick = mq[i].tag;
            end
            if (pick >= 0) resolve(pick, pred_of(pick));
            else idle(1);
        end
        idle(4);
        check("scoreboard_drained", exp_upd.size() + exp_mis.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpu_res_queue.md
Name: bpu_res_queue

Overview:
Tracks in-flight predicted branches between fetch and the branch unit, and is the producer side of the gshare update port (res_valid/res_taken/res_hist).
- Fetch allocates one entry per predicted branch and receives a tag.
- The branch unit resolves entries by tag, in any order; a mispredicting resolution squashes all younger entries.
- Resolved entries retire strictly in order, one per cycle, as registered predictor updates.

Parameters:
DEPTH, 8, queue entries; power of two, >= 2; TAGW = $clog2(DEPTH)
HLEN, 4, history/index width; must match the predictor HLEN

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
flush_i  in  1  pipeline flush, clears the queue
pred_valid_i  in  1  fetch presents a predicted branch
pred_ready_o  out  1  queue can accept an allocation
pred_hist_i  in  HLEN  PC index bits used for the prediction
pred_taken_i  in  1  predicted direction
pred_tag_o  out  TAGW  tag of the entry allocated this cycle (tail pointer)
res_valid_i  in  1  branch unit resolution
res_tag_i  in  TAGW  tag being resolved
res_taken_i  in  1  actual direction
mispred_o  out  1  registered pulse: resolution disagreed with prediction
mispred_tag_o  out  TAGW  tag of the mispredicted entry
upd_valid_o  out  1  predictor update valid (to gshare res_valid_i)
upd_taken_o  out  1  actual direction (to gshare res_taken_i)
upd_hist_o  out  HLEN  stored pred_hist (to gshare res_hist_i)

Behaviour:
Reset and flush values:
- rst_i (sync, highest priority) clears all of: head, tail, count; every entry's valid and resolved bit; and these outputs: upd_valid_o, upd_taken_o, upd_hist_o, mispred_o, mispred_tag_o.
- After reset, pred_ready_o=1 and pred_tag_o=0.
- flush_i (next priority) does the same clear.
- In a flush cycle, allocation, resolution and retirement are all ignored.

Entry state:
- Each entry holds {valid, resolved, hist, pred_taken, act_taken}.
- count has width TAGW+1.

Allocation:
- Fires on pred_valid_i && pred_ready_o.
- Writes the tail entry {valid=1, resolved=0}, then tail+1 mod DEPTH and count+1.
- pred_ready_o = (count != DEPTH) && !(res_valid_i && mispredict this cycle) && !flush_i.
- This ready is combinational from the resolution inputs.
- When full, allocation is refused even if a retirement happens in the same cycle.

Resolution:
- Fires on res_valid_i with a valid, unresolved entry.
- Sets resolved=1 and act_taken=res_taken_i.
- A resolution of an invalid or already-resolved tag is ignored and flagged by an assertion.
- mispredict = res_taken_i != pred_taken of the entry.
- On mispredict:
  - next cycle mispred_o=1 and mispred_tag_o=res_tag_i;
  - every entry after the tag up to the tail is invalidated;
  - tail <= res_tag_i+1;
  - count <= ((res_tag_i - head) mod DEPTH) + 1, minus 1 if a retirement happens in the same cycle.
- The mispredicted entry itself is kept and retires normally.

Retirement:
- If the head entry is valid and resolved, it retires:
  - next cycle upd_valid_o=1 with upd_taken_o/upd_hist_o from the entry;
  - the entry is invalidated, head+1 mod DEPTH, count-1.
- Otherwise upd_valid_o=0; upd_taken_o/upd_hist_o hold their last values.
- Throughput is at most one retirement per cycle.
- A resolution of the head entry becomes retirable in the following cycle, giving a 2-cycle latency from res_valid_i to upd_valid_o.

Simultaneous events:
- Allocate + retire: count unchanged.
- Allocate + mispredict: the allocation is refused.
- Resolve + retire of different entries: both take effect.

Wrap-around:
- Pointers wrap modulo DEPTH.
- Full means count==DEPTH; empty means count==0 (head==tail in both cases).

Decomposition:
- fetch_pkg: typedef bpu_rq_entry_t {resolved, hist[HLEN], pred_taken, act_taken}.
- len5_config_pkg: BPU_RQ_DEPTH constant.
- Single module. The per-entry valid vector, the pointers and count are local; no sub-module is warranted.

Test Plan:
- Reset: assert rst_i for 2 cycles -> pred_ready_o=1, pred_tag_o=0, upd_valid_o=0, mispred_o=0.
- In-order: allocate hist 3 (pred T) and 5 (pred NT), tags 0 and 1; resolve tag0 T, then tag1 NT -> upd_valid_o pulses with (T,3) then (NT,5); mispred_o stays 0; upd_valid_o comes 2 cycles after each res_valid_i.
- Out-of-order: allocate tags 0,1,2; resolve 2, then 1, then 0 -> no upd_valid_o until tag0 resolves; then 3 consecutive updates in order 0,1,2.
- Mispredict squash: allocate 0..4; resolve tag1 pred T actual NT -> next cycle mispred_o=1, mispred_tag_o=1; count=2; next allocation gets tag 2; a late resolve of old tag3 is ignored.
- Full/wrap with DEPTH=8: allocate 8 -> pred_ready_o=0 with pred_valid_i held high and no allocation; resolve and retire 3; allocate 3 more -> tags 0,1,2 reused; upd_hist_o follows allocation order.
- Flush mid-operation: 4 entries, 2 resolved; assert flush_i together with res_valid_i and pred_valid_i -> next cycle count=0, no upd_valid_o, no mispred_o, pred_tag_o=0.
